// File: rtl/line_mem_ctrl.sv
// Line memory controller: arbitrates demand and prefetch line requests onto a single
// line RAM port with a fixed request-to-response latency and one outstanding request.
module line_mem_ctrl #(
    parameter int unsigned LATENCY = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         dreq_valid,
    output logic         dreq_ready,
    input  logic [31:0]  dreq_addr,
    input  logic         dreq_wen,
    input  logic [127:0] dreq_wdata,
    input  logic         preq_valid,
    output logic         preq_ready,
    input  logic [31:0]  preq_addr,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [127:0] resp_rdata,
    output logic         resp_src,
    output logic         resp_wen,
    output logic [31:0]  ram_addr,
    output logic [127:0] ram_din,
    output logic         ram_we,
    input  logic [127:0] ram_dout
);

    // WAIT spans LATENCY-1 cycles, ACCESS one more, so RESP lands on the LATENCY-th edge.
    localparam logic [7:0] CntLoad = (LATENCY >= 2) ? 8'(LATENCY - 2) : 8'd0;

    typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic          wen_q, wen_d;
    logic [127:0]  wdata_q, wdata_d;
    logic          src_q, src_d;
    logic [127:0]  rdata_q, rdata_d;

    // Line offset bits are dropped on purpose; lines are always 16-byte aligned.
    logic unused_offset;
    assign unused_offset = ^{dreq_addr[3:0], preq_addr[3:0]};

    // State and request/response registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            addr_q  <= 32'd0;
            wen_q   <= 1'b0;
            wdata_q <= 128'd0;
            src_q   <= 1'b0;
            rdata_q <= 128'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            src_q   <= src_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state, request capture, RAM strobe and handshake outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        src_d      = src_q;
        rdata_d    = rdata_q;
        ram_we     = 1'b0;
        dreq_ready = (state_q == StIdle);
        preq_ready = (state_q == StIdle) & ~dreq_valid;

        unique case (state_q)
            StIdle: begin
                if (dreq_valid || preq_valid) begin
                    // Demand has priority; a pending prefetch simply keeps its valid up.
                    if (dreq_valid) begin
                        addr_d  = {dreq_addr[31:4], 4'h0};
                        wen_d   = dreq_wen;
                        wdata_d = dreq_wdata;
                        src_d   = 1'b0;
                    end else begin
                        addr_d  = {preq_addr[31:4], 4'h0};
                        wen_d   = 1'b0;
                        wdata_d = 128'd0;
                        src_d   = 1'b1;
                    end
                    if (LATENCY == 1) begin
                        state_d = StAccess;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CntLoad;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 8'd0) begin
                    state_d = StAccess;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StAccess: begin
                ram_we  = wen_q;
                rdata_d = wen_q ? 128'd0 : ram_dout;
                state_d = StResp;
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign resp_valid = (state_q == StResp);
    assign resp_rdata = rdata_q;
    assign resp_src   = src_q;
    assign resp_wen   = wen_q;
    assign ram_addr   = addr_q;
    assign ram_din    = wdata_q;

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Bench for line_mem_ctrl: two instances (LATENCY 4 and 1) each with a line RAM model,
// a scoreboard queue per instance and a forked monitor that checks every response.
module tb_line_mem_ctrl;

    typedef struct {
        logic [127:0] rdata;
        logic         src;
        logic         wen;
        logic [31:0]  addr;
        int           acc;
    } exp_t;

    logic                clk;
    logic                rstn;
    logic [1:0]          dv, dw, pv, rr;
    logic [1:0][31:0]    da, pa;
    logic [1:0][127:0]   dd;
    logic [1:0]          drdy, prdy, rv, rsrc, rwen, rwe;
    logic [1:0][31:0]    raddr;
    logic [1:0][127:0]   rdata, rdin, rdout;

    logic [127:0] mem0 [32];
    logic [127:0] mem1 [32];
    logic [127:0] init0 [32];
    logic [127:0] init1 [32];
    logic [127:0] mdl [2][32];
    logic         load;
    int           we_cnt0, we_cnt1;
    int           cyc;
    int           checks, errors;
    int           stall [2];
    int           nwr [2];
    bit           rnd_rr;
    exp_t         q0[$];
    exp_t         q1[$];

    line_mem_ctrl #(.LATENCY(4)) u_dut4 (
        .clk(clk), .rstn(rstn),
        .dreq_valid(dv[0]), .dreq_ready(drdy[0]), .dreq_addr(da[0]), .dreq_wen(dw[0]),
        .dreq_wdata(dd[0]), .preq_valid(pv[0]), .preq_ready(prdy[0]), .preq_addr(pa[0]),
        .resp_valid(rv[0]), .resp_ready(rr[0]), .resp_rdata(rdata[0]), .resp_src(rsrc[0]),
        .resp_wen(rwen[0]), .ram_addr(raddr[0]), .ram_din(rdin[0]), .ram_we(rwe[0]),
        .ram_dout(rdout[0])
    );

    line_mem_ctrl #(.LATENCY(1)) u_dut1 (
        .clk(clk), .rstn(rstn),
        .dreq_valid(dv[1]), .dreq_ready(drdy[1]), .dreq_addr(da[1]), .dreq_wen(dw[1]),
        .dreq_wdata(dd[1]), .preq_valid(pv[1]), .preq_ready(prdy[1]), .preq_addr(pa[1]),
        .resp_valid(rv[1]), .resp_ready(rr[1]), .resp_rdata(rdata[1]), .resp_src(rsrc[1]),
        .resp_wen(rwen[1]), .ram_addr(raddr[1]), .ram_din(rdin[1]), .ram_we(rwe[1]),
        .ram_dout(rdout[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line RAMs: 32 lines, anything with address bits [30:9] set reads zero and drops writes.
    assign rdout[0] = (raddr[0][30:9] != 22'd0) ? 128'd0 : mem0[raddr[0][8:4]];
    assign rdout[1] = (raddr[1][30:9] != 22'd0) ? 128'd0 : mem1[raddr[1][8:4]];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 32; i++) begin
                mem0[i] <= init0[i];
                mem1[i] <= init1[i];
            end
            we_cnt0 <= 0;
            we_cnt1 <= 0;
        end else begin
            if (rwe[0]) begin
                we_cnt0 <= we_cnt0 + 1;
                if (raddr[0][30:9] == 22'd0) mem0[raddr[0][8:4]] <= rdin[0];
            end
            if (rwe[1]) begin
                we_cnt1 <= we_cnt1 + 1;
                if (raddr[1][30:9] == 22'd0) mem1[raddr[1][8:4]] <= rdin[1];
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    // Reference: one outstanding request, so the response is known at issue time.
    function automatic exp_t model(input int k, input logic [31:0] addr, input bit wen,
                                   input logic [127:0] data, input bit pf);
        exp_t e;
        bit   inr = (addr[30:9] == 22'd0);
        int   idx = int'(addr[8:4]);
        e.src   = pf;
        e.wen   = wen;
        e.addr  = addr & 32'hFFFF_FFF0;
        e.rdata = 128'd0;
        e.acc   = 0;
        if (wen) begin
            if (inr) mdl[k][idx] = data;
        end else if (inr) begin
            e.rdata = mdl[k][idx];
        end
        return e;
    endfunction

    task automatic push(input int k, input exp_t e);
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic issue(input int k, input bit pf, input logic [31:0] addr, input bit wen,
                         input logic [127:0] data);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        if (pf) begin
            pv[k] = 1'b1;
            pa[k] = addr;
        end else begin
            dv[k] = 1'b1;
            da[k] = addr;
            dw[k] = wen;
            dd[k] = data;
        end
        #1;
        while (!(pf ? prdy[k] : drdy[k]) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL i%0d accept_timeout: ready never rose", k);
            dv[k] = 1'b0;
            pv[k] = 1'b0;
            return;
        end
        e = model(k, addr, pf ? 1'b0 : wen, data, pf);
        e.acc = cyc + 1;
        push(k, e);
        if (wen && !pf) nwr[k]++;
        @(posedge clk);
        #1;
        dv[k] = 1'b0;
        pv[k] = 1'b0;
        da[k] = $urandom;
        pa[k] = $urandom;
        dw[k] = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while ((qsize(k) != 0 || !drdy[k]) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL i%0d idle_timeout: pending %0d", k, qsize(k));
        end
    endtask

    // Drives resp_ready and checks each response against the scoreboard.
    task automatic monitor();
        bit   busy [2];
        bit   hs_prev [2];
        exp_t cur [2];
        int   lat;
        busy = '{0, 0};
        hs_prev = '{0, 0};
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                lat = (k == 0) ? 4 : 1;
                if (!rstn) begin
                    busy[k] = 0;
                    hs_prev[k] = 0;
                    rr[k] = 1'b0;
                end else begin
                    if (hs_prev[k]) begin
                        chk($sformatf("i%0d idle_after_handshake", k), 128'(drdy[k]), 128'd1);
                        hs_prev[k] = 0;
                    end
                    if (rv[k] && stall[k] > 0) begin
                        rr[k] = 1'b0;
                        stall[k]--;
                    end else begin
                        rr[k] = rnd_rr ? 1'($urandom_range(0, 1)) : 1'b1;
                    end
                    if (rv[k]) begin
                        if (!busy[k]) begin
                            if (qsize(k) == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL i%0d unexpected_resp: rdata %h", k, rdata[k]);
                                cur[k].rdata = rdata[k];
                                cur[k].src   = rsrc[k];
                                cur[k].wen   = rwen[k];
                            end else begin
                                cur[k] = (k == 0) ? q0.pop_front() : q1.pop_front();
                                chk($sformatf("i%0d rdata", k), rdata[k], cur[k].rdata);
                                chk($sformatf("i%0d src", k), 128'(rsrc[k]), 128'(cur[k].src));
                                chk($sformatf("i%0d wen", k), 128'(rwen[k]), 128'(cur[k].wen));
                                chk($sformatf("i%0d latency", k), 128'(cyc - cur[k].acc),
                                    128'(lat));
                                chk($sformatf("i%0d ram_addr", k), 128'(raddr[k]),
                                    128'(cur[k].addr));
                            end
                            busy[k] = 1;
                        end else begin
                            chk($sformatf("i%0d hold_stable", k),
                                {rdata[k][125:0], rsrc[k], rwen[k]},
                                {cur[k].rdata[125:0], cur[k].src, cur[k].wen});
                        end
                        chk($sformatf("i%0d dreq_ready_in_resp", k), 128'(drdy[k]), 128'd0);
                        if (rr[k]) begin
                            busy[k] = 0;
                            hs_prev[k] = 1;
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] line, a5, saved;
        int           wb, k, sel;
        bit           pf, wen;
        logic [31:0]  addr;

        checks = 0;
        errors = 0;
        rstn = 1'b0;
        load = 1'b1;
        rnd_rr = 1'b0;
        dv = '0; dw = '0; pv = '0; rr = '0; da = '0; pa = '0; dd = '0;
        stall = '{0, 0};
        nwr = '{0, 0};
        line = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        a5 = {16{8'hA5}};
        for (int i = 0; i < 32; i++) begin
            init0[i] = {$urandom, $urandom, $urandom, $urandom};
            init1[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        init0[1] = line;
        for (int i = 0; i < 32; i++) begin
            mdl[0][i] = init0[i];
            mdl[1][i] = init1[i];
        end
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("i%0d reset_resp_valid", i), 128'(rv[i]), 128'd0);
            chk($sformatf("i%0d reset_ram_we", i), 128'(rwe[i]), 128'd0);
            chk($sformatf("i%0d reset_outputs", i), rdata[i] | rdin[i] | 128'(raddr[i]),
                128'd0);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("i0 dreq_ready_after_reset", 128'(drdy[0]), 128'd1);

        // Demand read of an unaligned address in line 0x10.
        issue(0, 1'b0, 32'h0000_0013, 1'b0, 128'd0);
        wait_idle(0);

        // Write then read the same line: exactly one RAM write strobe.
        wb = we_cnt0;
        issue(0, 1'b0, 32'h0000_0020, 1'b1, a5);
        issue(0, 1'b0, 32'h0000_0020, 1'b0, 128'd0);
        wait_idle(0);
        chk("i0 one_write_pulse", 128'(we_cnt0 - wb), 128'd1);

        // Simultaneous demand and prefetch: demand first, prefetch held and served next.
        begin
            exp_t e;
            int   n = 0;
            @(negedge clk);
            dv[0] = 1'b1; da[0] = 32'h0000_0030; dw[0] = 1'b0;
            pv[0] = 1'b1; pa[0] = 32'h0000_0045;
            #1;
            chk("i0 preq_ready_blocked", 128'(prdy[0]), 128'd0);
            e = model(0, 32'h0000_0030, 1'b0, 128'd0, 1'b0);
            e.acc = cyc + 1;
            push(0, e);
            @(posedge clk);
            #1;
            dv[0] = 1'b0;
            while (!prdy[0] && n < 200) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("i0 prefetch_accepted", 128'(prdy[0]), 128'd1);
            e = model(0, 32'h0000_0045, 1'b0, 128'd0, 1'b1);
            e.acc = cyc + 1;
            push(0, e);
            @(posedge clk);
            #1;
            pv[0] = 1'b0;
            wait_idle(0);
        end

        // Response held off for ten cycles.
        stall[0] = 10;
        issue(0, 1'b0, 32'h0000_0050, 1'b0, 128'd0);
        wait_idle(0);

        // Reset while a write waits: no strobe, no response, ready right after release.
        saved = mdl[0][6];
        wb = we_cnt0;
        issue(0, 1'b0, 32'h0000_0064, 1'b1, {4{32'hDEAD_BEEF}});
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("i0 rst_resp_valid", 128'(rv[0]), 128'd0);
        chk("i0 rst_ram_we", 128'(rwe[0]), 128'd0);
        chk("i0 rst_zero_outputs", rdata[0] | rdin[0] | 128'(raddr[0]) |
            128'({rsrc[0], rwen[0]}), 128'd0);
        q0.delete();
        mdl[0][6] = saved;
        nwr[0]--;
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("i0 ready_after_release", 128'(drdy[0]), 128'd1);
        repeat (6) begin
            @(negedge clk);
            chk("i0 no_resp_after_reset", 128'(rv[0]), 128'd0);
        end
        chk("i0 no_write_after_reset", 128'(we_cnt0 - wb), 128'd0);
        issue(0, 1'b0, 32'h0000_0060, 1'b0, 128'd0);
        wait_idle(0);

        // LATENCY=1: out-of-range read returns zero after one edge.
        issue(1, 1'b0, 32'h0000_0400, 1'b0, 128'd0);
        issue(1, 1'b0, 32'h0000_0100, 1'b1, a5);
        issue(1, 1'b1, 32'h0000_0108, 1'b0, 128'd0);
        wait_idle(1);

        // Randomized traffic on both instances with random response back-pressure.
        rnd_rr = 1'b1;
        for (int i = 0; i < 80; i++) begin
            k    = int'($urandom_range(0, 1));
            pf   = ($urandom_range(0, 3) == 0);
            wen  = pf ? 1'b0 : 1'($urandom_range(0, 1));
            sel  = int'($urandom_range(0, 7));
            addr = $urandom;
            addr = (sel == 0) ? (addr | 32'h0000_0400) : (addr & 32'h8000_01FF);
            issue(k, pf, addr, wen, {$urandom, $urandom, $urandom, $urandom});
        end
        wait_idle(0);
        wait_idle(1);
        chk("i0 total_writes", 128'(we_cnt0), 128'(nwr[0]));
        chk("i1 total_writes", 128'(we_cnt1), 128'(nwr[1]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
